// File: rtl/sd_seq_pkg.sv
// sd_seq_pkg: shared states and sector geometry for the SD sector sequencer
package sd_seq_pkg;
  localparam int SECTOR_BYTES = 512;
  localparam int INDEX_W = 9;
  localparam logic [INDEX_W-1:0] LAST_INDEX = INDEX_W'(SECTOR_BYTES - 1);
  typedef enum logic [3:0] {
    IDLE, RD_REQ, RD_WAIT, BYTE, PATCH, WR_REQ, WR_WAIT,
    VF_REQ, VF_WAIT, VF_LAT, VF_CHK, NEXT
  } state_t;
  typedef enum logic [1:0] {BT_IDLE, BT_LAT, BT_SKIP, BT_WAIT} bt_state_t;
endpackage

// File: rtl/sd_sector_seq_if.sv
// sd_sector_seq_if: SD controller BRAM/command bus and UART transmit handshake
interface sd_sector_seq_if #(parameter int ADDR_W = 23) ();
  logic [ADDR_W-1:0] sd_addr;
  logic [8:0] sd_index;
  logic [7:0] sd_read_data;
  logic [7:0] sd_write_data;
  logic sd_write_enable;
  logic sd_read;
  logic sd_write;
  logic sd_busy;
  logic [7:0] tx_data;
  logic tx_go;
  logic tx_busy;
  modport master (
    output sd_addr, sd_index, sd_write_data, sd_write_enable, sd_read, sd_write, tx_data, tx_go,
    input sd_read_data, sd_busy, tx_busy
  );
  modport slave (
    input sd_addr, sd_index, sd_write_data, sd_write_enable, sd_read, sd_write, tx_data, tx_go,
    output sd_read_data, sd_busy, tx_busy
  );
endinterface

// File: rtl/sd_seq_byte_tx.sv
// sd_seq_byte_tx: one BRAM byte fetch then tx_go / tx_busy handshake
module sd_seq_byte_tx import sd_seq_pkg::*; (
  input  logic       CLK,
  input  logic       XRST,
  input  logic       i_start,
  input  logic [7:0] i_rd_data,
  input  logic       i_tx_busy,
  output logic [7:0] o_tx_data,
  output logic       o_tx_go,
  output logic       o_done
);
  bt_state_t r_state;
  logic [7:0] r_tx_data;
  logic r_tx_go, r_done;
  assign o_tx_data = r_tx_data;
  assign o_tx_go = r_tx_go;
  assign o_done = r_done;
  // wait one cycle for BRAM, send, ignore the cycle before tx_busy rises, wait for idle
  always_ff @(posedge CLK or negedge XRST) begin
    if (!XRST) begin
      r_state <= BT_IDLE;
      r_tx_data <= '0;
      r_tx_go <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_tx_go <= 1'b0;
      r_done <= 1'b0;
      case (r_state)
        BT_IDLE: if (i_start) r_state <= BT_LAT;
        BT_LAT: begin
          r_tx_data <= i_rd_data;
          r_tx_go <= 1'b1;
          r_state <= BT_SKIP;
        end
        BT_SKIP: r_state <= BT_WAIT;
        BT_WAIT: if (!i_tx_busy) begin
          r_done <= 1'b1;
          r_state <= BT_IDLE;
        end
        default: r_state <= BT_IDLE;
      endcase
    end
  end
endmodule

// File: rtl/sd_sector_seq.sv
// sd_sector_seq: reads consecutive SD sectors, dumps them over UART, optionally patches and verifies
module sd_sector_seq import sd_seq_pkg::*; #(
  parameter int ADDR_W = 23,
  parameter int NUM_SECTORS = 1,
  parameter logic [8:0] PATCH_INDEX = 9'h0FF,
  parameter logic [7:0] PATCH_VALUE = 8'hFF
) (
  input  logic              CLK,
  input  logic              XRST,
  input  logic              start,
  input  logic              mode,
  input  logic [ADDR_W-1:0] base_addr,
  sd_sector_seq_if.master   bus,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [15:0]       sector_cnt
);
  state_t r_state;
  logic r_mode, r_skip, r_rd, r_wr, r_we, r_tx_start, r_done, r_err;
  logic [ADDR_W-1:0] r_base, r_addr;
  logic [15:0] r_cnt;
  logic [8:0] r_index;
  logic [7:0] r_wdata;
  logic w_bt_done, w_last;
  assign w_last = ({1'b0, r_cnt} + 17'd1) == 17'(NUM_SECTORS);
  assign bus.sd_addr = r_addr;
  assign bus.sd_index = r_index;
  assign bus.sd_write_data = r_wdata;
  assign bus.sd_write_enable = r_we;
  assign bus.sd_read = r_rd;
  assign bus.sd_write = r_wr;
  assign busy = r_state != IDLE;
  assign done = r_done;
  assign error = r_err;
  assign sector_cnt = r_cnt;
  sd_seq_byte_tx u_byte_tx (
    .CLK(CLK), .XRST(XRST), .i_start(r_tx_start), .i_rd_data(bus.sd_read_data),
    .i_tx_busy(bus.tx_busy), .o_tx_data(bus.tx_data), .o_tx_go(bus.tx_go), .o_done(w_bt_done)
  );
  // run sequencer: command pulses are one cycle, each *_WAIT skips the cycle before sd_busy rises
  always_ff @(posedge CLK or negedge XRST) begin
    if (!XRST) begin
      r_state <= IDLE;
      r_mode <= 1'b0;
      r_skip <= 1'b0;
      r_rd <= 1'b0;
      r_wr <= 1'b0;
      r_we <= 1'b0;
      r_tx_start <= 1'b0;
      r_done <= 1'b0;
      r_err <= 1'b0;
      r_base <= '0;
      r_addr <= '0;
      r_cnt <= '0;
      r_index <= '0;
      r_wdata <= '0;
    end else begin
      r_rd <= 1'b0;
      r_wr <= 1'b0;
      r_we <= 1'b0;
      r_tx_start <= 1'b0;
      r_done <= 1'b0;
      case (r_state)
        IDLE: if (start) begin
          r_mode <= mode;
          r_base <= base_addr;
          r_err <= 1'b0;
          r_cnt <= '0;
          r_state <= RD_REQ;
        end
        RD_REQ: if (!bus.sd_busy) begin
          r_addr <= r_base + ADDR_W'(r_cnt);
          r_rd <= 1'b1;
          r_skip <= 1'b1;
          r_state <= RD_WAIT;
        end
        RD_WAIT: if (r_skip) r_skip <= 1'b0;
          else if (!bus.sd_busy) begin
            r_index <= '0;
            r_tx_start <= 1'b1;
            r_state <= BYTE;
          end
        BYTE: if (w_bt_done) begin
          if (r_index == LAST_INDEX) r_state <= r_mode ? PATCH : NEXT;
          else begin
            r_index <= r_index + 9'd1;
            r_tx_start <= 1'b1;
          end
        end
        PATCH: begin
          r_index <= PATCH_INDEX;
          r_wdata <= PATCH_VALUE;
          r_we <= 1'b1;
          r_state <= WR_REQ;
        end
        WR_REQ: if (!bus.sd_busy) begin
          r_wr <= 1'b1;
          r_skip <= 1'b1;
          r_state <= WR_WAIT;
        end
        WR_WAIT: if (r_skip) r_skip <= 1'b0;
          else if (!bus.sd_busy) r_state <= VF_REQ;
        VF_REQ: if (!bus.sd_busy) begin
          r_rd <= 1'b1;
          r_skip <= 1'b1;
          r_state <= VF_WAIT;
        end
        VF_WAIT: if (r_skip) r_skip <= 1'b0;
          else if (!bus.sd_busy) begin
            r_index <= PATCH_INDEX;
            r_state <= VF_LAT;
          end
        VF_LAT: r_state <= VF_CHK;
        VF_CHK: begin
          if (bus.sd_read_data != PATCH_VALUE) r_err <= 1'b1;
          r_state <= NEXT;
        end
        NEXT: begin
          r_cnt <= r_cnt + 16'd1;
          r_done <= w_last;
          r_state <= w_last ? IDLE : RD_REQ;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sd_sector_seq.sv
// tb_sd_sector_seq: scoreboard bench with SD controller, BRAM and UART models
module tb_sd_sector_seq;
  logic CLK = 1'b0;
  logic XRST = 1'b0;
  logic start = 1'b0;
  logic mode = 1'b0;
  logic [22:0] base_addr = '0;
  logic busy, done, error;
  logic [15:0] sector_cnt;
  sd_sector_seq_if #(.ADDR_W(23)) bus ();
  sd_sector_seq #(.ADDR_W(23), .NUM_SECTORS(3)) dut (
    .CLK(CLK), .XRST(XRST), .start(start), .mode(mode), .base_addr(base_addr),
    .bus(bus), .busy(busy), .done(done), .error(error), .sector_cnt(sector_cnt)
  );
  always #5 CLK = ~CLK;
  int n_chk = 0, n_fail = 0, n_tx = 0, n_done = 0, first_rd = -1, cyc = 0, cbusy = 0, ubusy = 0;
  logic [7:0] exp_tx[$];
  logic [22:0] exp_rd[$], exp_wr[$];
  logic [7:0] mem[512], wbuf[512];
  logic wvalid = 1'b0, store = 1'b0, hold_busy = 1'b1;
  logic [22:0] waddr = '0;
  logic [7:0] seed = '0;
  assign bus.sd_busy = hold_busy || cbusy != 0;
  assign bus.tx_busy = ubusy != 0;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  always @(posedge CLK) cyc <= cyc + 1;
  // card + BRAM + UART model; the card holds (index ^ seed) unless a stored write exists
  always @(posedge CLK) begin
    if (bus.sd_write_enable) mem[bus.sd_index] <= bus.sd_write_data;
    bus.sd_read_data <= mem[bus.sd_index];
    ubusy <= bus.tx_go ? 1 : (ubusy > 0 ? ubusy - 1 : 0);
    if (bus.sd_write) begin
      cbusy <= 10;
      if (store) begin
        wvalid <= 1'b1;
        waddr <= bus.sd_addr;
        wbuf <= mem;
      end
    end else if (bus.sd_read) begin
      cbusy <= 10;
      for (int i = 0; i < 512; i++)
        mem[i] <= (wvalid && waddr == bus.sd_addr) ? wbuf[i] : (8'(i) ^ seed);
    end else if (cbusy > 0) cbusy <= cbusy - 1;
  end
  // scoreboard: pop and compare on every DUT pulse
  always @(negedge CLK) if (XRST) begin
    if (bus.tx_go) begin
      n_tx++;
      chk("tx_expected", 32'(exp_tx.size() != 0), 1);
      if (exp_tx.size() != 0) chk("tx_byte", bus.tx_data, exp_tx.pop_front());
    end
    if (bus.sd_read) begin
      if (first_rd < 0) first_rd = cyc;
      chk("rd_expected", 32'(exp_rd.size() != 0), 1);
      if (exp_rd.size() != 0) chk("rd_addr", bus.sd_addr, exp_rd.pop_front());
    end
    if (bus.sd_write) begin
      chk("wr_expected", 32'(exp_wr.size() != 0), 1);
      if (exp_wr.size() != 0) chk("wr_addr", bus.sd_addr, exp_wr.pop_front());
    end
    if (bus.sd_write_enable) begin
      chk("we_index", bus.sd_index, 9'h0FF);
      chk("we_data", bus.sd_write_data, 8'hFF);
    end
    if (bus.sd_read | bus.sd_write | bus.tx_go | bus.sd_write_enable)
      chk("pulse_onehot", 32'($onehot({bus.sd_read, bus.sd_write, bus.tx_go, bus.sd_write_enable})), 1);
    if (done) begin
      n_done++;
      chk("busy_at_done", busy, 0);
    end
  end
  task automatic push_run(input logic m, input logic [22:0] b);
    for (int k = 0; k < 3; k++) begin
      exp_rd.push_back(b + 23'(k));
      for (int i = 0; i < 512; i++) exp_tx.push_back(8'(i) ^ seed);
      if (m) begin
        exp_wr.push_back(b + 23'(k));
        exp_rd.push_back(b + 23'(k));
      end
    end
  endtask
  task automatic pulse_start(input logic m, input logic [22:0] b);
    @(negedge CLK);
    start = 1'b1;
    mode = m;
    base_addr = b;
    @(negedge CLK);
    start = 1'b0;
    mode = ~m;
    base_addr = '1;
  endtask
  task automatic wait_done(input string tag);
    int d0 = n_done;
    int n = 0;
    while (n_done == d0 && n < 20000) begin
      @(posedge CLK);
      n++;
    end
    chk({tag, "_done"}, 32'(n_done - d0), 1);
    repeat (5) @(negedge CLK);
    chk({tag, "_done_once"}, 32'(n_done - d0), 1);
    chk({tag, "_sector_cnt"}, sector_cnt, 3);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_tx_left"}, 32'(exp_tx.size()), 0);
    chk({tag, "_rd_left"}, 32'(exp_rd.size()), 0);
    chk({tag, "_wr_left"}, 32'(exp_wr.size()), 0);
  endtask
  initial begin
    int rel, n0, n1, n;
    repeat (2) @(negedge CLK);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
    chk("rst_sector_cnt", sector_cnt, 0);
    chk("rst_index", bus.sd_index, 0);
    chk("rst_addr", bus.sd_addr, 0);
    chk("rst_pulses", {bus.sd_read, bus.sd_write, bus.sd_write_enable, bus.tx_go}, 0);
    XRST = 1'b1;
    seed = 8'h00;
    push_run(1'b0, 23'h10);
    repeat (3) @(negedge CLK);
    pulse_start(1'b0, 23'h10);
    repeat (44) @(negedge CLK);
    chk("no_rd_while_sd_busy", first_rd, -1);
    chk("busy_while_waiting", busy, 1);
    hold_busy = 1'b0;
    rel = cyc;
    wait_done("dump");
    chk("rd_after_release", 32'(first_rd > rel), 1);
    chk("dump_error", error, 0);
    store = 1'b1;
    push_run(1'b1, 23'h200);
    pulse_start(1'b1, 23'h200);
    wait_done("patch_ok");
    chk("patch_ok_error", error, 0);
    chk("patch_card_byte", wbuf[255], 8'hFF);
    store = 1'b0;
    seed = 8'h5A;
    push_run(1'b1, 23'h300);
    pulse_start(1'b1, 23'h300);
    wait_done("patch_drop");
    chk("patch_drop_error", error, 1);
    repeat (20) @(negedge CLK);
    chk("error_held", error, 1);
    seed = 8'h00;
    push_run(1'b0, 23'h7FFFFE);
    pulse_start(1'b0, 23'h7FFFFE);
    chk("error_cleared_on_start", error, 0);
    wait_done("wrap");
    chk("wrap_error", error, 0);
    push_run(1'b0, 23'h40);
    n0 = n_tx;
    pulse_start(1'b0, 23'h40);
    n = 0;
    while (n_tx - n0 < 100 && n < 5000) begin
      @(posedge CLK);
      n++;
    end
    chk("reach_byte100", 32'(n_tx - n0 >= 100), 1);
    @(negedge CLK);
    XRST = 1'b0;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_sector_cnt", sector_cnt, 0);
    chk("midrst_index", bus.sd_index, 0);
    chk("midrst_tx_go", bus.tx_go, 0);
    exp_tx.delete();
    exp_rd.delete();
    repeat (3) @(negedge CLK);
    XRST = 1'b1;
    n1 = n_tx;
    repeat (20) @(negedge CLK);
    chk("no_stray_tx_go", 32'(n_tx - n1), 0);
    chk("idle_after_reset", busy, 0);
    push_run(1'b0, 23'h40);
    pulse_start(1'b0, 23'h40);
    wait_done("restart");
    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end
endmodule
